// File: rtl/wire_share_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters take turns driving one
// shared 1-bit wire. The granted requester keeps the wire until it drops its
// request, or until it has held it for MAX_HOLD cycles while someone else is
// waiting.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | no owner, out = IDLE_VAL, arbitrate from r_rr_ptr
//   S_OWNED | r_owner drives out, tenure tracked by r_hold_cnt
module wire_share_arbiter #(
  parameter int   N_REQ    = 4,
  parameter int   MAX_HOLD = 8,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         din,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     out
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t          r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_hold_cnt;
  logic [IW-1:0]   r_rr_ptr;

  state_t          w_state_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [IW-1:0]   w_owner_nxt;
  logic [CW-1:0]   w_hold_nxt;
  logic [IW-1:0]   w_rr_nxt;

  logic [N_REQ-1:0] w_owner_oh;
  logic [IW-1:0]   w_owner_inc;
  logic [IW-1:0]   w_search_start;
  logic [N_REQ-1:0] w_search_mask;
  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic [N_REQ-1:0] w_winner_oh;
  logic            w_others_req;
  logic            w_release;
  logic            w_busy;

  assign w_owner_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
  assign w_others_req = |(req & ~w_owner_oh);
  assign w_release    = !req[r_owner] || ((r_hold_cnt == HOLD_LAST) && w_others_req);

  // Search origin and candidate set: idle arbitrates from the round-robin
  // pointer; a releasing owner hands off starting just past itself.
  always_comb begin
    w_search_start = r_rr_ptr;
    w_search_mask  = req;
    if (r_state == S_OWNED) begin
      w_search_start = w_owner_inc;
      w_search_mask  = req & ~w_owner_oh;
    end
  end

  // Circular priority search: lowest index at/after the origin wins, else the
  // lowest index before it (wrap-around). The second loop overrides the first.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_search_mask[i] && (IW'(i) < w_search_start)) begin
        w_found  = 1'b1;
        w_winner = IW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_search_mask[i] && (IW'(i) >= w_search_start)) begin
        w_found  = 1'b1;
        w_winner = IW'(i);
      end
    end
  end

  assign w_winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;

  // Next-state, grant and tenure bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    w_rr_nxt    = r_rr_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWNED;
          w_grant_nxt = w_winner_oh;
          w_owner_nxt = w_winner;
          w_hold_nxt  = '0;
        end
      end
      S_OWNED: begin
        if (w_release) begin
          w_rr_nxt = w_owner_inc;
          if (w_found) begin
            w_grant_nxt = w_winner_oh;
            w_owner_nxt = w_winner;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_owner_nxt = '0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold_cnt != HOLD_LAST) begin
          // Saturates so a lone owner can keep the wire indefinitely.
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  // Only the owner's bit is selected, so unknowns on other din bits never
  // reach the wire.
  assign w_busy = |r_grant;
  assign grant  = r_grant;
  assign owner  = r_owner;
  assign busy   = w_busy;
  assign out    = w_busy ? din[r_owner] : IDLE_VAL;

endmodule

// File: tb/tb_wire_share_arbiter.sv
// Directed bench for wire_share_arbiter (N_REQ=4, MAX_HOLD=8, IDLE_VAL=0).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_wire_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       wire_out;

  int n_checks;
  int n_fail;

  wire_share_arbiter #(
    .N_REQ   (4),
    .MAX_HOLD(8),
    .IDLE_VAL(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .din  (din),
    .grant(grant),
    .owner(owner),
    .busy (busy),
    .out  (wire_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    din   = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b want=0000", grant); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++;
    if (wire_out !== 1'b0) begin n_fail++; $display("FAIL reset_out got=%b want=0", wire_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b want=0001", grant); end
    n_checks++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_first_owner got=%0d want=0", owner); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    din = 4'bx0xx;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b want=0100", grant); end
    n_checks++;
    if (owner !== 2'd2) begin n_fail++; $display("FAIL single_owner got=%0d want=2", owner); end
    n_checks++;
    if (wire_out !== 1'b0) begin n_fail++; $display("FAIL single_out0 got=%b want=0", wire_out); end
    din = 4'bx1xx;
    #1;
    n_checks++;
    if (wire_out !== 1'b1) begin n_fail++; $display("FAIL single_out1 got=%b want=1", wire_out); end
    din = 4'b1011;
    #1;
    n_checks++;
    if (wire_out !== 1'b0) begin n_fail++; $display("FAIL single_out2 got=%b want=0", wire_out); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_drop_grant got=%b want=0000", grant); end
    n_checks++;
    if (busy !== 1'b0 || wire_out !== 1'b0) begin
      n_fail++; $display("FAIL single_drop_idle busy=%b out=%b want busy=0 out=0", busy, wire_out);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_owner;
    do_reset();
    din = 4'b0000;
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      exp_owner = 2'((c / 8) % 4);
      n_checks++;
      if (owner !== exp_owner || grant !== (4'b0001 << exp_owner) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fairness cycle=%0d got owner=%0d grant=%b busy=%b want owner=%0d", c, owner, grant, busy, exp_owner);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL wrap_setup_owner got=%0d want=3", owner); end
    req = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (owner !== 2'd0 || grant !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_handoff got owner=%0d grant=%b want owner=0 grant=0001", owner, grant);
    end
  endtask

  task automatic test_overstay();
    do_reset();
    din = 4'b0010;
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0010 || wire_out !== 1'b1) begin
        n_fail++; $display("FAIL overstay_hold cycle=%0d got grant=%b out=%b want grant=0010 out=1", c, grant, wire_out);
      end
    end
    req = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (owner !== 2'd0 || grant !== 4'b0001) begin
      n_fail++; $display("FAIL overstay_handoff got owner=%0d grant=%b want owner=0 grant=0001", owner, grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Leave the round-robin pointer at 3 before taking owner 1.
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    din = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (owner !== 2'd1) begin n_fail++; $display("FAIL mid_setup_owner got=%0d want=1", owner); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || wire_out !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got grant=%b busy=%b out=%b want 0000/0/0", grant, busy, wire_out);
    end
    rst_n = 1'b1;
    // Pointer back at 0 means requester 1 beats requester 3.
    req = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (owner !== 2'd1 || grant !== 4'b0010) begin
      n_fail++; $display("FAIL mid_rr_restart got owner=%0d grant=%b want owner=1 grant=0010", owner, grant);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    din      = 4'b0000;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_overstay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
